// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the UART transmit frame sequencer:
//   - state_e   : frame phase encoding (IDLE, START, DATA, PARITY, STOP)
//   - SEL_*     : TX output mux select codes
//   - PAR_*     : parity type codes (PAR_TYP input)
// -----------------------------------------------------------------------------
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_DATA  = 2'b01;
  localparam logic [1:0] SEL_PAR   = 2'b10;
  localparam logic [1:0] SEL_STOP  = 2'b11;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// Load/shift register plus data-bit counter for one UART payload.
// Ports:
//   clk_i       bit-rate clock
//   rst_ni      asynchronous reset, active-low
//   load_i      capture data_i and clear the bit counter
//   data_i      parallel payload
//   shift_en_i  advance to the next payload bit (asserted on DATA edges)
//   ser_out_o   current payload bit (LSB first)
//   ser_done_o  current bit is the last payload bit
// -----------------------------------------------------------------------------
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  shift_en_i,
  output logic                  ser_out_o,
  output logic                  ser_done_o
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Next-state for shifter and counter; the counter saturates at the last bit
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sh_d  = data_i;
      cnt_d = {CNT_W{1'b0}};
    end else if (shift_en_i) begin
      sh_d = {1'b0, sh_q[DATA_WIDTH-1:1]};
      if (cnt_q != CNT_LAST) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      sh_d  = sh_q;
      cnt_d = cnt_q;
    end
  end

  // Shifter and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q  <= {DATA_WIDTH{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign ser_out_o  = sh_q[0];
  assign ser_done_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
// UART transmit frame sequencer: start, DATA_WIDTH data bits (LSB first),
// optional parity, stop. One CLK period is one bit time.
// Ports:
//   CLK, RST    baud clock (rising edge), asynchronous active-low reset
//   P_DATA      payload, captured on accept
//   DATA_VALID  payload strobe; accepted only when not busy
//   PAR_EN      parity enable, captured on accept
//   PAR_TYP     parity type (0 even, 1 odd), captured on accept
//   MUX_SEL     TX mux select (00 start, 01 data, 10 parity, 11 stop/idle)
//   SER_DATA    current payload bit; holds its last value outside DATA
//   PAR_BIT     parity of the captured payload; held until the next accept
//   BUSY        frame in progress
//   FRAME_DONE  high during the stop-bit cycle
// Build option: define UART_TX_B2B_EN to accept a new payload in STOP and go
// straight to START (back-to-back frames without an idle cycle).
// -----------------------------------------------------------------------------
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            MUX_SEL,
  output logic                  SER_DATA,
  output logic                  PAR_BIT,
  output logic                  BUSY,
  output logic                  FRAME_DONE
);

  // Even parity is the XOR-reduction; odd parity is its inverse.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                       input logic typ);
    return (^data) ^ (typ == PAR_ODD);
  endfunction

  state_e state_q, state_d;
  logic   par_en_q, par_en_d;
  logic   par_bit_q, par_bit_d;
  logic   ser_hold_q, ser_hold_d;
  logic   arm_q;
  logic   accept_s;
  logic   ser_out_s;
  logic   ser_done_s;

  // arm_q is low on the first edge after reset release, which blocks an accept
  // on that edge even when DATA_VALID is already high.
`ifdef UART_TX_B2B_EN
  assign accept_s = DATA_VALID & arm_q & ((state_q == IDLE) | (state_q == STOP));
`else
  assign accept_s = DATA_VALID & arm_q & (state_q == IDLE);
`endif

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .load_i     (accept_s),
    .data_i     (P_DATA),
    .shift_en_i (state_q == DATA),
    .ser_out_o  (ser_out_s),
    .ser_done_o (ser_done_s)
  );

  // Next-state logic and captured frame configuration
  always_comb begin
    state_d    = state_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    ser_hold_d = (state_q == DATA) ? ser_out_s : ser_hold_q;
    if (accept_s) begin
      par_en_d  = PAR_EN;
      par_bit_d = calc_parity(P_DATA, PAR_TYP);
    end else begin
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
    end
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = START;
        else          state_d = IDLE;
      end
      START: state_d = DATA;
      DATA: begin
        if (ser_done_s) state_d = par_en_q ? PARITY : STOP;
        else            state_d = DATA;
      end
      PARITY: state_d = STOP;
      STOP: begin
        if (accept_s) state_d = START;
        else          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and configuration registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      ser_hold_q <= 1'b0;
      arm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      ser_hold_q <= ser_hold_d;
      arm_q      <= 1'b1;
    end
  end

  // Moore output decode from the state register
  always_comb begin
    MUX_SEL    = SEL_STOP;
    BUSY       = 1'b0;
    FRAME_DONE = 1'b0;
    case (state_q)
      IDLE:    begin MUX_SEL = SEL_STOP;  BUSY = 1'b0; FRAME_DONE = 1'b0; end
      START:   begin MUX_SEL = SEL_START; BUSY = 1'b1; FRAME_DONE = 1'b0; end
      DATA:    begin MUX_SEL = SEL_DATA;  BUSY = 1'b1; FRAME_DONE = 1'b0; end
      PARITY:  begin MUX_SEL = SEL_PAR;   BUSY = 1'b1; FRAME_DONE = 1'b0; end
      STOP:    begin MUX_SEL = SEL_STOP;  BUSY = 1'b1; FRAME_DONE = 1'b1; end
      default: begin MUX_SEL = SEL_STOP;  BUSY = 1'b0; FRAME_DONE = 1'b0; end
    endcase
  end

  // Live shifter bit during DATA, otherwise the last bit sent
  assign SER_DATA = (state_q == DATA) ? ser_out_s : ser_hold_q;
  assign PAR_BIT  = par_bit_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Directed, table-driven bench for uart_tx_ctrl with DATA_WIDTH=8. Inputs are
// driven and outputs sampled on the falling edge of CLK.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [1:0] MUX_SEL;
  logic       SER_DATA;
  logic       PAR_BIT;
  logic       BUSY;
  logic       FRAME_DONE;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic       ep;    // hand-computed expected PAR_BIT
    int         mode;  // 0 plain, 1 change inputs mid-frame, 2 DATA_VALID pulse mid-frame
  } vec_t;

  vec_t vecs [7];

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .MUX_SEL    (MUX_SEL),
    .SER_DATA   (SER_DATA),
    .PAR_BIT    (PAR_BIT),
    .BUSY       (BUSY),
    .FRAME_DONE (FRAME_DONE)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_ctl(input string tag, input logic [1:0] mux, input logic busy,
                           input logic done);
    check({tag, ".mux"},  {6'd0, MUX_SEL},    {6'd0, mux});
    check({tag, ".busy"}, {7'd0, BUSY},       {7'd0, busy});
    check({tag, ".done"}, {7'd0, FRAME_DONE}, {7'd0, done});
  endtask

  task automatic check_idle(input string tag);
    check_ctl({tag, ".idle"}, 2'b11, 1'b0, 1'b0);
  endtask

  // Called at the falling edge just before the accepting rising edge; returns
  // at the falling edge inside the stop-bit cycle.
  task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe,
                              input logic ep, input int mode, input logic hold);
    @(negedge CLK);
    check_ctl({tag, ".start"}, 2'b00, 1'b1, 1'b0);
    if (!hold) DATA_VALID = 1'b0;
    if (mode == 3) P_DATA = 8'h18;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      check_ctl($sformatf("%s.d%0d", tag, k), 2'b01, 1'b1, 1'b0);
      check($sformatf("%s.ser%0d", tag, k), {7'd0, SER_DATA}, {7'd0, d[k]});
      check($sformatf("%s.par%0d", tag, k), {7'd0, PAR_BIT}, {7'd0, ep});
      if (k == 3 && mode == 1) begin
        P_DATA  = 8'hFF;
        PAR_TYP = ~PAR_TYP;
        PAR_EN  = ~PAR_EN;
      end
      if (k == 3 && mode == 2) begin
        P_DATA     = 8'h3C;
        DATA_VALID = 1'b1;
      end
      if (k == 4 && mode == 2) DATA_VALID = 1'b0;
    end
    if (pe) begin
      @(negedge CLK);
      check_ctl({tag, ".parity"}, 2'b10, 1'b1, 1'b0);
      check({tag, ".parbit"}, {7'd0, PAR_BIT}, {7'd0, ep});
    end
    @(negedge CLK);
    check_ctl({tag, ".stop"}, 2'b11, 1'b1, 1'b1);
    check({tag, ".stoppar"}, {7'd0, PAR_BIT}, {7'd0, ep});
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, pe: 1'b0, pt: 1'b0, ep: 1'b0, mode: 0};
    vecs[1] = '{data: 8'hA5, pe: 1'b1, pt: 1'b0, ep: 1'b0, mode: 0};
    vecs[2] = '{data: 8'hA5, pe: 1'b1, pt: 1'b1, ep: 1'b1, mode: 0};
    vecs[3] = '{data: 8'h07, pe: 1'b1, pt: 1'b0, ep: 1'b1, mode: 1};
    vecs[4] = '{data: 8'hA5, pe: 1'b0, pt: 1'b0, ep: 1'b0, mode: 2};
    vecs[5] = '{data: 8'hC3, pe: 1'b1, pt: 1'b1, ep: 1'b1, mode: 0};
    vecs[6] = '{data: 8'h01, pe: 1'b0, pt: 1'b1, ep: 1'b0, mode: 0};

    RST        = 1'b0;
    P_DATA     = 8'h00;
    DATA_VALID = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;

    // Reset values
    repeat (2) @(negedge CLK);
    check_idle("rst");
    check("rst.ser", {7'd0, SER_DATA}, 8'd0);
    check("rst.par", {7'd0, PAR_BIT},  8'd0);
    RST = 1'b1;
    @(negedge CLK);
    check_idle("post_rst");

    // Table-driven single frames
    for (int i = 0; i < 7; i++) begin
      P_DATA     = vecs[i].data;
      PAR_EN     = vecs[i].pe;
      PAR_TYP    = vecs[i].pt;
      DATA_VALID = 1'b1;
      expect_frame($sformatf("v%0d", i), vecs[i].data, vecs[i].pe, vecs[i].ep,
                   vecs[i].mode, 1'b0);
      @(negedge CLK);
      check_idle($sformatf("v%0d.end", i));
      check($sformatf("v%0d.serhold", i), {7'd0, SER_DATA}, {7'd0, vecs[i].data[7]});
      @(negedge CLK);
      check_idle($sformatf("v%0d.end2", i));
    end

    // Reset during data bit 4 of an 8'hFF odd-parity frame
    P_DATA     = 8'hFF;
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b1;
    DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    repeat (5) @(negedge CLK);
    check_ctl("mid.bit4", 2'b01, 1'b1, 1'b0);
    check("mid.ser4", {7'd0, SER_DATA}, 8'd1);
    check("mid.par",  {7'd0, PAR_BIT},  8'd1);
    #2 RST = 1'b0;
    #1;
    check_idle("mid.rst");
    check("mid.rst.ser", {7'd0, SER_DATA}, 8'd0);
    check("mid.rst.par", {7'd0, PAR_BIT},  8'd0);
    P_DATA     = 8'h5A;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    DATA_VALID = 1'b1;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_idle("rel.noaccept");
    expect_frame("f5A", 8'h5A, 1'b0, 1'b0, 0, 1'b0);
    @(negedge CLK);
    check_idle("f5A.end");

    // DATA_VALID held high across two frames
    P_DATA     = 8'h81;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    DATA_VALID = 1'b1;
    expect_frame("b81", 8'h81, 1'b0, 1'b0, 3, 1'b1);
`ifdef UART_TX_B2B_EN
    expect_frame("b18", 8'h18, 1'b0, 1'b0, 0, 1'b1);
`else
    @(negedge CLK);
    check_idle("gap");
    expect_frame("b18", 8'h18, 1'b0, 1'b0, 0, 1'b1);
`endif
    DATA_VALID = 1'b0;
    @(negedge CLK);
    check_idle("b18.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
